// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 style bus ports: word width, the idle bus
// value and the buffer occupancy classification.
package sap1_pkg;

    localparam int WORD_WIDTH = 8;
    localparam logic [WORD_WIDTH-1:0] BUS_IDLE = {WORD_WIDTH{1'bz}};

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    // Classifies a word count against the buffer depth.
    function automatic occ_e occ_of(input int unsigned count, input int unsigned depth);
        if (count == 32'd0) begin
            return OCC_EMPTY;
        end else if (count >= depth) begin
            return OCC_FULL;
        end else begin
            return OCC_PARTIAL;
        end
    endfunction

endpackage

// File: rtl/port_fifo.sv
// Circular word buffer for the input port: tail write, head read, occupancy count.
// Push is ignored when full and pop is ignored when empty, so the count cannot wrap.
module port_fifo
    import sap1_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Next pointers and count; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = i_push && (count_q != CNT_W'(DEPTH));
        do_pop   = i_pop && (count_q != {CNT_W{1'b0}});
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_reset) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge i_clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // Storage is left unreset; a cleared count makes stale words unreachable.
    always_ff @(posedge i_clk) begin
        if (do_push && !i_reset) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/input_port.sv
// External input port: ready/valid intake into a small buffer, sticky overflow
// flag, and a tri-state driver that pops one word per enabled cycle onto the bus.
module input_port
    import sap1_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_debug,
    input  logic             i_ext_valid,
    input  logic [WIDTH-1:0] i_ext_data,
    output logic             o_ext_ready,
    input  logic             i_output_enable,
    output logic [WIDTH-1:0] o_bus,
    output logic             o_data_available,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] bus_val;
    logic             push, pop;
    logic             overflow_q, overflow_d;
    occ_e             occ;

    port_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_data  (i_ext_data),
        .i_pop   (pop),
        .o_count (o_count),
        .o_head  (head)
    );

    assign occ              = occ_of(32'(o_count), DEPTH);
    assign o_ext_ready      = (occ != OCC_FULL);
    assign o_data_available = (occ != OCC_EMPTY);
    assign push             = i_ext_valid && o_ext_ready;
    assign pop              = i_output_enable && o_data_available;

    // Sticky overflow: set by any offer that meets a full buffer.
    always_comb begin
        overflow_d = overflow_q;
        if (i_reset) begin
            overflow_d = 1'b0;
        end else if (i_ext_valid && !o_ext_ready) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge i_clk) begin
        overflow_q <= overflow_d;
    end

    assign o_overflow = overflow_q;

    // An empty buffer drives zero rather than a stale word when enabled.
    always_comb begin
        bus_val = {WIDTH{1'b0}};
        if (o_data_available) begin
            bus_val = head;
        end else begin
            bus_val = {WIDTH{1'b0}};
        end
    end

    assign o_bus = i_output_enable ? bus_val : {WIDTH{BUS_IDLE[0]}};

`ifndef SYNTHESIS
    // Optional trace of reset, push and pop events.
    always_ff @(posedge i_clk) begin
        if (i_debug) begin
            if (i_reset) begin
                $display("input_port: reset");
            end else begin
                if (push) $display("input_port: push %0h count %0d", i_ext_data, o_count);
                if (pop)  $display("input_port: pop  %0h count %0d", head, o_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_input_port.sv
// Bench for input_port: queue reference model checked every cycle, a table of
// fill/overflow/drain vectors, and hand sequences for the corner cases.
module tb_input_port;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst, dbg, valid, oe;
    logic [W-1:0] data;
    wire  [W-1:0] bus;
    logic         ready, avail, ovf;
    logic [2:0]   count;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] sb_q[$];
    logic         m_ovf;
    logic [W-1:0] bus_seen;

    input_port #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_debug          (dbg),
        .i_ext_valid      (valid),
        .i_ext_data       (data),
        .o_ext_ready      (ready),
        .i_output_enable  (oe),
        .o_bus            (bus),
        .o_data_available (avail),
        .o_count          (count),
        .o_overflow       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       oe;
        logic       chk_bus;
        logic [7:0] exp_bus;
        logic [2:0] exp_cnt;
        logic       exp_rdy;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check the bus before the edge against
    // the scoreboard head, update the model, check registered state after the edge.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic e);
        logic [7:0] exp_bus;
        logic       m_ready;
        @(negedge clk);
        rst = r; valid = v; data = d; oe = e;
        #1;
        bus_seen = bus;
        if (e && !r) begin
            exp_bus = (sb_q.size() > 0) ? sb_q[0] : 8'h00;
            chk("bus", {24'd0, bus}, {24'd0, exp_bus});
        end
        if (r) begin
            sb_q.delete();
            m_ovf = 1'b0;
        end else begin
            m_ready = (sb_q.size() != D);
            if (v && !m_ready) m_ovf = 1'b1;
            if (e && sb_q.size() > 0) void'(sb_q.pop_front());
            if (v && m_ready) sb_q.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("count", {29'd0, count}, 32'(sb_q.size()));
        chk("ready", {31'd0, ready}, {31'd0, sb_q.size() != D});
        chk("avail", {31'd0, avail}, {31'd0, sb_q.size() != 0});
        chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
    endtask

    initial begin
        rst = 1'b1; dbg = 1'b0; valid = 1'b0; data = 8'h00; oe = 1'b0;
        m_ovf = 1'b0;

        // fill to full, overflow, drain, then enable while empty
        vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 3'd2, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 3'd4, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 3'd3, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 3'd2, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 3'd1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 3'd0, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 3'd0, 1'b1, 1'b1};

        // reset with enable low, then single push and single pop
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        cycle(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("a5_count", {29'd0, count}, 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("a5_bus", {24'd0, bus_seen}, 32'h0000_00A5);
        chk("a5_count_after", {29'd0, count}, 32'd0);

        // table-driven fill / overflow / drain
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, vecs[i].v, vecs[i].d, vecs[i].oe);
            if (vecs[i].chk_bus) chk($sformatf("vec%0d_bus", i), {24'd0, bus_seen}, {24'd0, vecs[i].exp_bus});
            chk($sformatf("vec%0d_cnt", i), {29'd0, count}, {29'd0, vecs[i].exp_cnt});
            chk($sformatf("vec%0d_rdy", i), {31'd0, ready}, {31'd0, vecs[i].exp_rdy});
            chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
        end

        // streaming: valid and enable held together from empty
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'h10 + 8'(i), 1'b1);
            chk($sformatf("stream%0d_bus", i), {24'd0, bus_seen}, (i == 0) ? 32'h0 : 32'(8'h10 + 8'(i - 1)));
            chk($sformatf("stream%0d_le1", i), {31'd0, count <= 3'd1}, 32'd1);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // full buffer: enable pops, simultaneous offer is blocked and flagged
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h20 + 8'(i), 1'b0);
        cycle(1'b0, 1'b1, 8'h2F, 1'b1);
        chk("full_pop_bus", {24'd0, bus_seen}, 32'h20);
        chk("full_pop_cnt", {29'd0, count}, 32'd3);
        chk("full_pop_ovf", {31'd0, ovf}, 32'd1);

        // reset alongside push and enable with 3 words held
        cycle(1'b1, 1'b1, 8'h77, 1'b1);
        chk("midrst_cnt", {29'd0, count}, 32'd0);
        chk("midrst_rdy", {31'd0, ready}, 32'd1);
        chk("midrst_ovf", {31'd0, ovf}, 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("midrst_bus", {24'd0, bus_seen}, 32'h0);

        // pointer wrap: 6 push/pop pairs on top of 3 held words
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 8'h40 + 8'(i), 1'b1);
            chk($sformatf("wrap%0d_bus", i), {24'd0, bus_seen}, (i < 3) ? 32'(8'h30 + 8'(i)) : 32'(8'h40 + 8'(i - 3)));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // random traffic against the scoreboard, with trace enabled briefly
        dbg = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i == 8) dbg = 1'b0;
            cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_port.md
INPUT_PORT -- requirements
Module: input_port

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, as the data word width.
REQ-002 The block SHALL have parameter DEPTH, default 4, as the buffer depth in words (power of two, at least 2).
REQ-003 i_clk  input  1  the single clock; all state SHALL change only on the rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset, sampled on the rising edge of i_clk.
REQ-005 i_debug  input  1  when high, SHALL print $display trace lines on push, pop and reset.
REQ-006 i_ext_valid  input  1  the external source offers i_ext_data this cycle.
REQ-007 i_ext_data  input  WIDTH  external data word.
REQ-008 o_ext_ready  output  1  the port can accept a word this cycle.
REQ-009 i_output_enable  input  1  controller request to place the head word on the shared bus.
REQ-010 o_bus  output  WIDTH  tri-state buffered bus driver.
REQ-011 o_data_available  output  1  the buffer holds at least one word.
REQ-012 o_count  output  $clog2(DEPTH)+1  number of words currently held.
REQ-013 o_overflow  output  1  sticky flag; a word was offered while the buffer was full.

Function
REQ-014 o_ext_ready SHALL equal (o_count != DEPTH), combinationally from registered state.
REQ-015 A push SHALL occur on a rising edge with i_ext_valid=1 and o_ext_ready=1; i_ext_data is written at the tail.
REQ-016 o_bus SHALL be all-z when i_output_enable=0.
REQ-017 With i_output_enable=1, o_bus SHALL drive the head word if o_count>0, else all-zero.
REQ-018 A pop SHALL occur on each rising edge with i_output_enable=1 and o_count>0.
  - Exactly one word per cycle of enable.
  - The head advances after the edge.
REQ-019 Push and pop on the same edge SHALL both take effect; o_count is unchanged.
REQ-020 When empty, a simultaneous push and enable SHALL accept the push and pop nothing; that cycle's bus value is 0.
REQ-021 When full, the enable SHALL pop; o_ext_ready=0 blocks a push that same edge, with no bypass.
REQ-022 i_ext_valid=1 while o_ext_ready=0 SHALL set o_overflow on that edge; o_overflow is cleared only by reset.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; o_count SHALL never exceed DEPTH or underflow below 0.
REQ-024 o_data_available SHALL equal (o_count != 0).
REQ-025 Occupancy states SHALL be EMPTY (count 0), PARTIAL and FULL (count DEPTH), with transitions by push-only (+1) or pop-only (-1) only.
REQ-026 Write-to-read latency SHALL be one cycle: a word pushed at edge N is visible on o_bus (when enabled) after edge N.

Reset
REQ-027 i_reset=1 at a rising edge SHALL clear both pointers, o_count and o_overflow, overriding any push or pop on that edge.
REQ-028 After reset: o_ext_ready=1, o_data_available=0, o_count=0, o_overflow=0.
REQ-029 After reset, o_bus SHALL be z if enable is low, or 0 if enable is high.
REQ-030 Buffer storage contents SHALL NOT require reset.
REQ-031 A reset mid-stream SHALL discard all buffered words.

Structure
REQ-032 WORD_WIDTH (8) and the bus-idle constant (all-z) SHALL live in the shared package sap1_pkg.
REQ-033 Storage and pointers SHALL be a sub-module port_fifo (push, pop, count, head out).
REQ-034 input_port SHALL add the handshake, overflow flag and tri-state bus driver around port_fifo.

Verification
REQ-035 Reset with enable low; push 8'hA5 -> o_bus z; o_count=1; enable high for one cycle -> o_bus=8'hA5, then count 0.
REQ-036 Push 8'h01..8'h04 with DEPTH 4 -> o_ext_ready=0; valid with 8'h05 -> o_overflow=1; pops return 01,02,03,04.
REQ-037 Hold valid and enable together for 10 cycles with incrementing data from 8'h10 -> bus sequence 00,10,11,... and o_count stays at or below 1.
REQ-038 Enable high while empty -> o_bus=8'h00; o_count stays 0; no pop.
REQ-039 Fill with 3 words, assert reset alongside push and enable -> next cycle count 0, ready 1, o_overflow 0.
REQ-040 Drive 6 push/pop pairs through DEPTH 4 -> data order preserved across pointer wrap.
